fetch_sequencer: RTL and testbench

Controller that sequences the program counter register and the instruction-memory fetch handshake. Each cycle it computes the PC register's next address and stall input. It arbitrates between sequential fetch, branch redirect (EX) and jump redirect (ID), and holds fetch for load-use hazards. Redirects that arrive while a fetch is outstanding are buffered and applied once that fetch completes.

---
 rtl/fetch_sequencer.sv | 126 ++++++++++++
 tb/tb_fetch_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the PC register's next address/stall and the imem fetch
// handshake, arbitrating sequential fetch, branch/jump redirects and load-use holds.
module fetch_sequencer #(
    parameter int unsigned     WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned     PC_STEP      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_cur,
    output logic [WIDTH-1:0] pc_next,
    output logic             pc_stall,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic             hazard_stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jmp_valid,
    input  logic [WIDTH-1:0] jmp_target,
    output logic             fetch_valid,
    output logic             ifid_flush,
    output logic [31:0]      stall_cycles
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;
    logic [31:0]      stall_cycles_q, stall_cycles_d;

    logic             redir;
    logic [WIDTH-1:0] redir_target;

    // Branch beats jump; a jump held by a load-use hazard is re-presented by decode.
    assign redir        = br_taken | (jmp_valid & ~hazard_stall);
    assign redir_target = br_taken ? br_target : jmp_target;

    assign imem_addr    = pc_cur;
    assign stall_cycles = stall_cycles_q;

    always_comb begin
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        pc_next       = pc_cur;
        pc_stall      = 1'b0;
        imem_req      = 1'b0;
        fetch_valid   = 1'b0;
        ifid_flush    = 1'b0;

        if (!reset) begin
            pc_next       = RESET_VECTOR;
            state_d       = BOOT;
            pend_valid_d  = 1'b0;
            pend_target_d = '0;
        end else begin
            unique case (state_q)
                BOOT: begin
                    pc_next = RESET_VECTOR;
                    state_d = FETCH;
                end
                FETCH: begin
                    imem_req = 1'b1;
                    if (!imem_ready) begin
                        // Fetch outstanding: PC must hold, so a redirect is parked.
                        pc_stall = 1'b1;
                        if (redir) begin
                            ifid_flush    = 1'b1;
                            pend_target_d = redir_target;
                            pend_valid_d  = 1'b1;
                            state_d       = DRAIN;
                        end
                    end else if (redir) begin
                        pc_next    = redir_target;
                        ifid_flush = 1'b1;
                    end else if (hazard_stall) begin
                        pc_stall = 1'b1;
                    end else begin
                        pc_next     = pc_cur + WIDTH'(PC_STEP);
                        fetch_valid = 1'b1;
                    end
                end
                DRAIN: begin
                    imem_req = 1'b1;
                    if (br_taken) begin
                        ifid_flush    = 1'b1;
                        pend_target_d = br_target;
                    end
                    if (!imem_ready) begin
                        pc_stall = 1'b1;
                    end else begin
                        pc_next      = br_taken ? br_target : pend_target_q;
                        pend_valid_d = 1'b0;
                        state_d      = FETCH;
                    end
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end

        stall_cycles_d = reset ? (stall_cycles_q + 32'(pc_stall)) : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= BOOT;
            pend_valid_q   <= 1'b0;
            pend_target_q  <= '0;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            pend_valid_q   <= pend_valid_d;
            pend_target_q  <= pend_target_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: models the PC register and the sequencing rules
// behaviourally, then runs directed scenarios followed by random traffic.
module tb_fetch_sequencer;

    localparam logic [31:0] RV   = 32'h0000_0000;
    localparam logic [31:0] STEP = 32'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        pc_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        hazard_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        fetch_valid;
    logic        ifid_flush;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    fetch_sequencer #(.WIDTH(32), .RESET_VECTOR(RV), .PC_STEP(4)) dut (
        .clk(clk), .reset(reset), .pc_cur(pc_cur), .pc_next(pc_next),
        .pc_stall(pc_stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .hazard_stall(hazard_stall),
        .br_taken(br_taken), .br_target(br_target),
        .jmp_valid(jmp_valid), .jmp_target(jmp_target),
        .fetch_valid(fetch_valid), .ifid_flush(ifid_flush),
        .stall_cycles(stall_cycles)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference model: "boot pending" flag, a queue holding at most one parked
    // redirect (non-empty means a fetch is being drained), the PC register, stall count.
    bit          m_boot;
    logic [31:0] m_pend[$];
    logic [31:0] m_pc;
    logic [31:0] m_stalls;
    logic [31:0] e_next;
    logic        e_stall, e_req, e_fv, e_flush;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic predict();
        logic        jump_ok;
        logic [31:0] tgt;
        jump_ok = jmp_valid && !hazard_stall;
        tgt     = br_taken ? br_target : jmp_target;
        e_next  = m_pc;
        e_stall = 1'b0;
        e_req   = 1'b0;
        e_fv    = 1'b0;
        e_flush = 1'b0;
        if (!reset || m_boot) begin
            e_next = RV;
        end else if (m_pend.size() != 0) begin
            e_req   = 1'b1;
            e_flush = br_taken;
            e_stall = !imem_ready;
            if (imem_ready) e_next = br_taken ? br_target : m_pend[0];
        end else begin
            e_req = 1'b1;
            if (!imem_ready) begin
                e_stall = 1'b1;
                e_flush = br_taken || jump_ok;
            end else if (br_taken || jump_ok) begin
                e_next  = tgt;
                e_flush = 1'b1;
            end else if (hazard_stall) begin
                e_stall = 1'b1;
            end else begin
                e_next = m_pc + STEP;
                e_fv   = 1'b1;
            end
        end
    endtask

    task automatic commit();
        logic jump_ok;
        jump_ok = jmp_valid && !hazard_stall;
        if (!reset) begin
            m_boot   = 1'b1;
            m_pend.delete();
            m_stalls = 32'd0;
        end else begin
            if (e_stall) m_stalls = m_stalls + 32'd1;
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (m_pend.size() != 0) begin
                if (imem_ready) m_pend.delete();
                else if (br_taken) m_pend[0] = br_target;
            end else if (!imem_ready && (br_taken || jump_ok)) begin
                m_pend.push_back(br_taken ? br_target : jmp_target);
            end
        end
        if (!e_stall) m_pc = e_next;
    endtask

    task automatic step(input logic rst, input logic rdy, input logic hz,
                        input logic br, input logic [31:0] bt,
                        input logic jv, input logic [31:0] jt);
        @(negedge clk);
        reset = rst; imem_ready = rdy; hazard_stall = hz;
        br_taken = br; br_target = bt; jmp_valid = jv; jmp_target = jt;
        #1;
        predict();
        check("imem_req", 32'(imem_req), 32'(e_req));
        check("pc_stall", 32'(pc_stall), 32'(e_stall));
        check("fetch_valid", 32'(fetch_valid), 32'(e_fv));
        check("ifid_flush", 32'(ifid_flush), 32'(e_flush));
        check("imem_addr", imem_addr, m_pc);
        if (!e_stall) check("pc_next", pc_next, e_next);
        @(posedge clk);
        #1;
        commit();
        pc_cur = m_pc;
        check("stall_cycles", stall_cycles, m_stalls);
    endtask

    initial begin
        reset = 1'b0; imem_ready = 1'b1; hazard_stall = 1'b0;
        br_taken = 1'b0; br_target = '0; jmp_valid = 1'b0; jmp_target = '0;
        pc_cur = 32'hDEAD_BEE0; m_pc = pc_cur;
        m_boot = 1'b1; m_stalls = 32'd0;

        // Reset release with ready tied high: 0 (reset), 0 (boot), 4, 8
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        check("pc_after_reset", imem_addr, 32'h0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        check("seq_pc8", imem_addr, 32'h8);
        check("no_stalls_yet", stall_cycles, 32'd0);

        // Memory wait of 3 cycles at pc 8
        repeat (3) step(1, 0, 0, 0, 0, 0, 0);
        check("wait_stall_count", stall_cycles, 32'd3);
        check("wait_addr_held", imem_addr, 32'h8);
        step(1, 1, 0, 0, 0, 0, 0);
        check("after_wait_pc", imem_addr, 32'hC);
        step(1, 1, 0, 0, 0, 0, 0);

        // Branch with ready at pc 0x10
        step(1, 1, 0, 1, 32'h100, 0, 0);
        check("branch_pc", imem_addr, 32'h100);
        step(1, 1, 0, 1, 32'h20, 0, 0);

        // Branch during a wait at 0x20, ready two cycles later
        step(1, 0, 0, 1, 32'h200, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("drain_addr_held", imem_addr, 32'h20);
        step(1, 1, 0, 0, 0, 0, 0);
        check("drain_pc", imem_addr, 32'h200);

        // Jump held by hazard, then taken; branch beats jump
        step(1, 1, 1, 0, 0, 1, 32'h40);
        check("jump_held", imem_addr, 32'h200);
        step(1, 1, 0, 0, 0, 1, 32'h40);
        check("jump_pc", imem_addr, 32'h40);
        step(1, 1, 0, 1, 32'h80, 1, 32'h40);
        check("branch_over_jump", imem_addr, 32'h80);

        // Reset in the middle of a drain discards the parked target
        step(1, 0, 0, 1, 32'h300, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        check("no_stale_redirect", imem_addr, 32'h4);

        // Sequential wrap at the top of the address space
        step(1, 1, 0, 1, 32'hFFFF_FFFC, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        check("wrap_pc", imem_addr, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 5) == 0), $urandom() & 32'hFFFF_FFFC,
                 ($urandom_range(0, 4) == 0), $urandom() & 32'hFFFF_FFFC);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
